// File: rtl/led_blink_sequencer.sv
// Turns a one-cycle start pulse into N timed on/off LED blinks followed by a done pulse.
// Outputs are registered alongside the state so they never glitch on the LED pin.
module led_blink_sequencer #(
  parameter int CLKS_ON     = 25000,
  parameter int CLKS_OFF    = 25000,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic [COUNT_WIDTH-1:0] i_Count,
  output logic                   o_LED,
  output logic                   o_Busy,
  output logic                   o_Done
);

  localparam int MAX_CLKS = (CLKS_ON > CLKS_OFF) ? CLKS_ON : CLKS_OFF;
  localparam int TW       = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(CLKS_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(CLKS_OFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [COUNT_WIDTH-1:0] remaining;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      remaining <= '0;
      o_LED     <= 1'b0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            o_Busy <= 1'b1;
            if (i_Count != '0) begin
              remaining <= i_Count;
              timer     <= '0;
              state     <= S_ON;
              o_LED     <= 1'b1;
            end else begin
              state  <= S_DONE;
              o_Done <= 1'b1;
            end
          end
        end
        S_ON: begin
          // remaining is at least 1 here, so the decrement cannot underflow
          if (timer == ON_LAST) begin
            timer     <= '0;
            remaining <= remaining - 1'b1;
            state     <= S_OFF;
            o_LED     <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_OFF: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            if (remaining == '0) begin
              state  <= S_DONE;
              o_Done <= 1'b1;
            end else begin
              state <= S_ON;
              o_LED <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_Busy <= 1'b0;
          o_Done <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_LED  <= 1'b0;
          o_Busy <= 1'b0;
          o_Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: two instances (4/3 and 1/1 timing) checked against
// a sequence-level model that predicts outputs from start time and blink count.
module tb_led_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [2];
  logic [3:0] cnt   [2];
  logic       led   [2];
  logic       busy  [2];
  logic       done  [2];

  int total = 0;
  int bad   = 0;

  int     on_c  [2] = '{4, 1};
  int     off_c [2] = '{3, 1};
  longint cyc = 0;
  longint seq_start [2];
  int     seq_n     [2];
  bit     seq_valid [2];

  always #5 clk = ~clk;

  led_blink_sequencer #(.CLKS_ON(4), .CLKS_OFF(3), .COUNT_WIDTH(4)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start[0]), .i_Count(cnt[0]),
    .o_LED(led[0]), .o_Busy(busy[0]), .o_Done(done[0])
  );

  led_blink_sequencer #(.CLKS_ON(1), .CLKS_OFF(1), .COUNT_WIDTH(4)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start[1]), .i_Count(cnt[1]),
    .o_LED(led[1]), .o_Busy(busy[1]), .o_Done(done[1])
  );

  // Busy length of a sequence: N full on/off periods plus the done cycle.
  function automatic longint seq_len(int d);
    return longint'(seq_n[d]) * (on_c[d] + off_c[d]) + 1;
  endfunction

  function automatic bit model_idle(int d);
    return !seq_valid[d] || (cyc >= seq_start[d] + seq_len(d) + 1);
  endfunction

  // {led, busy, done} expected just after edge cyc; u counts cycles since acceptance.
  function automatic logic [2:0] exp_out(int d);
    longint u, l, p;
    if (!seq_valid[d]) return 3'b000;
    p = on_c[d] + off_c[d];
    l = seq_len(d);
    u = cyc - seq_start[d];
    if (u < 0 || u >= l) return 3'b000;
    if (u == l - 1) return 3'b011;
    return {logic'((u % p) < on_c[d]), 2'b10};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (start[d] && model_idle(d)) begin
          seq_start[d] = cyc;
          seq_n[d]     = int'(cnt[d]);
          seq_valid[d] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({led[d], busy[d], done[d]} !== 3'b000) begin
          bad++;
          $display("FAIL reset_held d=%0d cyc=%0d got=%b exp=000", d, cyc, {led[d], busy[d], done[d]});
        end
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({led[d], busy[d], done[d]} !== exp_out(d)) begin
          bad++;
          $display("FAIL reset_idle d=%0d cyc=%0d got=%b exp=%b", d, cyc, {led[d], busy[d], done[d]}, exp_out(d));
        end
      end
    end
  endtask

  task automatic test_two_blinks();
    int done_u = -1;
    int led_cycles = 0;
    start[0] = 1'b1; cnt[0] = 4'd2;
    tick();
    start[0] = 1'b0;
    for (int u = 0; u < 20; u++) begin
      if (u > 0) tick();
      total++;
      if ({led[0], busy[0], done[0]} !== exp_out(0)) begin
        bad++;
        $display("FAIL two_blinks u=%0d got=%b exp=%b", u, {led[0], busy[0], done[0]}, exp_out(0));
      end
      if (done[0] === 1'b1) done_u = u;
      if (led[0] === 1'b1) led_cycles++;
    end
    total++;
    if (done_u != 14) begin
      bad++;
      $display("FAIL two_blinks_done_at got=%0d exp=14", done_u);
    end
    total++;
    if (led_cycles != 8) begin
      bad++;
      $display("FAIL two_blinks_led_cycles got=%0d exp=8", led_cycles);
    end
  endtask

  task automatic test_zero_count();
    int busy_cycles = 0;
    int led_cycles  = 0;
    tick();
    start[0] = 1'b1; cnt[0] = 4'd0;
    tick();
    start[0] = 1'b0;
    total++;
    if ({led[0], busy[0], done[0]} !== 3'b011) begin
      bad++;
      $display("FAIL zero_count_first got=%b exp=011", {led[0], busy[0], done[0]});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy[0] === 1'b1) busy_cycles++;
      if (led[0] === 1'b1) led_cycles++;
      total++;
      if ({led[0], busy[0], done[0]} !== exp_out(0)) begin
        bad++;
        $display("FAIL zero_count_after i=%0d got=%b exp=%b", i, {led[0], busy[0], done[0]}, exp_out(0));
      end
    end
    total++;
    if (busy_cycles != 0 || led_cycles != 0) begin
      bad++;
      $display("FAIL zero_count_tail busy=%0d led=%0d exp=0/0", busy_cycles, led_cycles);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int rises = 0;
    logic prev_led = 1'b0;
    tick();
    start[0] = 1'b1; cnt[0] = 4'd3;
    tick();
    start[0] = 1'b0;
    for (int u = 0; u < 30; u++) begin
      if (u > 0) tick();
      start[0] = (u == 4);
      cnt[0]   = (u == 4) ? 4'd1 : 4'($urandom_range(1, 15));
      total++;
      if ({led[0], busy[0], done[0]} !== exp_out(0)) begin
        bad++;
        $display("FAIL ignore_start u=%0d got=%b exp=%b", u, {led[0], busy[0], done[0]}, exp_out(0));
      end
      if (done[0] === 1'b1) dones++;
      if (led[0] === 1'b1 && prev_led === 1'b0) rises++;
      prev_led = led[0];
    end
    start[0] = 1'b0;
    total++;
    if (dones != 1 || rises != 3) begin
      bad++;
      $display("FAIL ignore_start_counts dones=%0d blinks=%0d exp=1/3", dones, rises);
    end
  endtask

  task automatic test_async_reset();
    tick();
    start[0] = 1'b1; cnt[0] = 4'd3;
    tick();
    start[0] = 1'b0;
    for (int u = 1; u <= 8; u++) tick();
    total++;
    if ({led[0], busy[0]} !== 2'b11) begin
      bad++;
      $display("FAIL async_pre got=%b exp=11", {led[0], busy[0]});
    end
    rst = 1'b1;
    seq_valid[0] = 1'b0;
    seq_valid[1] = 1'b0;
    #1;
    total++;
    if ({led[0], busy[0], done[0]} !== 3'b000) begin
      bad++;
      $display("FAIL async_immediate got=%b exp=000", {led[0], busy[0], done[0]});
    end
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({led[d], busy[d], done[d]} !== 3'b000) begin
          bad++;
          $display("FAIL async_after d=%0d i=%0d got=%b exp=000", d, i, {led[d], busy[d], done[d]});
        end
      end
    end
  endtask

  task automatic test_fast_max();
    int done_u = -1;
    int led_cycles = 0;
    start[1] = 1'b1; cnt[1] = 4'd15;
    tick();
    start[1] = 1'b0;
    for (int u = 0; u < 36; u++) begin
      if (u > 0) tick();
      total++;
      if ({led[1], busy[1], done[1]} !== exp_out(1)) begin
        bad++;
        $display("FAIL fast_max u=%0d got=%b exp=%b", u, {led[1], busy[1], done[1]}, exp_out(1));
      end
      if (done[1] === 1'b1) done_u = u;
      if (led[1] === 1'b1) led_cycles++;
    end
    total++;
    if (done_u != 30 || led_cycles != 15) begin
      bad++;
      $display("FAIL fast_max_summary done_at=%0d led=%0d exp=30/15", done_u, led_cycles);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      for (int d = 0; d < 2; d++) begin
        start[d] = (i >= 1000) ? 1'b1 : ($urandom_range(0, 9) == 0);
        cnt[d]   = 4'($urandom_range(0, 15));
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({led[d], busy[d], done[d]} !== exp_out(d)) begin
          bad++;
          $display("FAIL random d=%0d cyc=%0d got=%b exp=%b", d, cyc, {led[d], busy[d], done[d]}, exp_out(d));
        end
      end
    end
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      cnt[d] = 4'd0;
      seq_valid[d] = 1'b0;
      seq_start[d] = 0;
      seq_n[d] = 0;
    end
    test_reset();
    test_two_blinks();
    test_zero_count();
    test_ignore_start();
    test_async_reset();
    test_fast_max();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Output-side companion to the switch/LED edge-toggle logic: that logic turns a switch edge into an LED state change; this block turns a one-cycle command pulse into a timed LED pattern.
- On a start pulse, it drives the LED through N on/off blink cycles with parameterised on and off durations.
- It then reports completion with a one-cycle done pulse.
- Sits between board-level control logic (e.g. a switch edge detector) and an LED pin.

Parameters:
- CLKS_ON, 25000, clock cycles LED is lit per blink; must be ≥1.
- CLKS_OFF, 25000, clock cycles LED is dark after each blink; must be ≥1.
- COUNT_WIDTH, 4, width of the blink-count input.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  reset; asynchronous, active-high.
- i_Start  input  1  one-cycle request pulse; sampled on rising edge of i_Clk.
- i_Count  input  COUNT_WIDTH  number of blinks; sampled only in the cycle i_Start is accepted.
- o_LED  output  1  LED drive, 1 = lit.
- o_Busy  output  1  high while a sequence is in progress (ON, OFF, DONE states).
- o_Done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Interface:
  - One clock, i_Clk.
  - Reset i_Rst is asynchronous and active-high.
  - While i_Rst=1: state=IDLE, o_LED=0, o_Busy=0, o_Done=0, timer=0, remaining count=0.
- States: IDLE, ON, OFF, DONE.
- All outputs are registered and are decoded from state: o_LED=1 only in ON; o_Busy=1 in ON/OFF/DONE; o_Done=1 only in DONE.
- IDLE:
  - If i_Start=1 and i_Count≠0: latch i_Count into remaining, clear timer, go to ON.
  - If i_Start=1 and i_Count=0: go to DONE (no blink).
  - Otherwise stay in IDLE.
- Latency: if i_Start is high at edge k, o_LED=1 from edge k+1.
- ON:
  - o_LED=1 for exactly CLKS_ON cycles.
  - Timer counts 0..CLKS_ON-1; at CLKS_ON-1, clear timer, decrement remaining, go to OFF.
- OFF:
  - o_LED=0 for exactly CLKS_OFF cycles.
  - At the terminal timer count: if remaining=0, go to DONE; else clear timer and go to ON.
- DONE: exactly one cycle, then IDLE. A new start is accepted from the cycle after DONE.
- Total busy time for N≥1 is N·(CLKS_ON+CLKS_OFF)+1 cycles. For N=0 it is 1 cycle.
- i_Start while o_Busy=1 is ignored. It is not queued, and i_Count changes mid-sequence have no effect.
- i_Start held high continuously: a new sequence starts every time IDLE is reached.
- Max count 2^COUNT_WIDTH-1 must work without wrap; remaining must not underflow.
- Timer width is $clog2 of the larger of CLKS_ON and CLKS_OFF, minimum 1 bit.
- CLKS_ON=1 or CLKS_OFF=1 must give single-cycle phases with no extra cycles.
- Reset asserted mid-sequence: outputs go to reset values immediately, with no done pulse. After release the block stays in IDLE until a fresh i_Start.

Test Plan (CLKS_ON=4, CLKS_OFF=3, COUNT_WIDTH=4 unless stated):
- Reset release, no start -> o_LED=0, o_Busy=0, o_Done=0 held for 50 cycles.
- Start pulse with i_Count=2 at edge 0 -> o_LED high on edges 1-4 and 8-11, low otherwise; o_Done=1 only at edge 15; o_Busy high for edges 1-15.
- Start with i_Count=0 -> o_Done=1 and o_Busy=1 for exactly one cycle at edge 1; o_LED never high.
- Start (i_Count=3), then a second start (i_Count=1) at edge 5 and i_Count changed mid-run -> exactly 3 blinks; second start ignored; one done pulse.
- i_Rst asserted asynchronously in the middle of the second ON phase -> o_LED, o_Busy, o_Done go 0 without waiting for a clock edge; no done pulse; block idle after release.
- CLKS_ON=1, CLKS_OFF=1, i_Count=15 -> LED alternates 1/0 for 30 cycles; o_Done at edge 31; no count wrap.
